// File: rtl/sha256_nonce_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : sha256_nonce_scheduler_if
// Brief   : Job, core-control and shared memory port bundle for the scheduler
// Revision: 1.0
// ============================================================================
interface sha256_nonce_scheduler_if;
  logic        start;
  logic        abort;
  logic [31:0] nonce_base;
  logic [31:0] nonce_count;
  logic [31:0] target_word;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic        busy;
  logic        done;
  logic        found;
  logic        error;
  logic [31:0] found_nonce;
  logic [31:0] found_hash0;
  logic [31:0] nonces_tried;
  logic        core_rst_n;
  logic        core_start;
  logic        core_done;
  logic        core_mem_we;
  logic [15:0] core_mem_addr;
  logic [31:0] core_mem_write_data;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  start, abort, nonce_base, nonce_count, target_word, message_addr, output_addr,
    output busy, done, found, error, found_nonce, found_hash0, nonces_tried,
    output core_rst_n, core_start,
    input  core_done, core_mem_we, core_mem_addr, core_mem_write_data,
    output mem_we, mem_addr, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output start, abort, nonce_base, nonce_count, target_word, message_addr, output_addr,
    input  busy, done, found, error, found_nonce, found_hash0, nonces_tried,
    input  core_rst_n, core_start,
    output core_done, core_mem_we, core_mem_addr, core_mem_write_data,
    input  mem_we, mem_addr, mem_write_data,
    output mem_read_data
  );
endinterface
`default_nettype wire

// File: rtl/sha256_nonce_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : sha256_nonce_scheduler
// Brief   : Walks one SHA-256 core over a nonce range and records the first hit
// Revision: 1.0
// ============================================================================
module sha256_nonce_scheduler #(
  parameter logic [15:0] NONCE_OFFSET   = 16'd19,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd200,
  parameter logic        STOP_ON_HIT    = 1'b1
) (
  input  wire logic               clk,
  input  wire logic               reset,
  sha256_nonce_scheduler_if.slave sched_if
);
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RESET_CORE = 3'd1,
    S_START_CORE = 3'd2,
    S_WAIT_CORE  = 3'd3,
    S_RD_ADDR    = 3'd4,
    S_RD_WAIT    = 3'd5,
    S_CHECK      = 3'd6,
    S_FINISH     = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] nonce_q, nonce_d, count_q, count_d, target_q, target_d;
  logic [31:0] found_nonce_q, found_nonce_d, found_hash0_q, found_hash0_d;
  logic [31:0] tried_q, tried_d;
  logic [15:0] msg_addr_q, msg_addr_d, out_addr_q, out_addr_d, timer_q, timer_d;
  logic        busy_q, busy_d, done_q, done_d, found_q, found_d, error_q, error_d;
  logic        hit;
  logic        core_owns_mem;

  assign hit = sched_if.mem_read_data < target_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      nonce_q       <= '0;
      count_q       <= '0;
      target_q      <= '0;
      found_nonce_q <= '0;
      found_hash0_q <= '0;
      tried_q       <= '0;
      msg_addr_q    <= '0;
      out_addr_q    <= '0;
      timer_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      nonce_q       <= nonce_d;
      count_q       <= count_d;
      target_q      <= target_d;
      found_nonce_q <= found_nonce_d;
      found_hash0_q <= found_hash0_d;
      tried_q       <= tried_d;
      msg_addr_q    <= msg_addr_d;
      out_addr_q    <= out_addr_d;
      timer_q       <= timer_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      found_q       <= found_d;
      error_q       <= error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    nonce_d       = nonce_q;
    count_d       = count_q;
    target_d      = target_q;
    found_nonce_d = found_nonce_q;
    found_hash0_d = found_hash0_q;
    tried_d       = tried_q;
    msg_addr_d    = msg_addr_q;
    out_addr_d    = out_addr_q;
    timer_d       = timer_q;
    busy_d        = busy_q;
    done_d        = done_q;
    found_d       = found_q;
    error_d       = error_q;
    case (state_q)
      S_IDLE: begin
        if (sched_if.start && !sched_if.abort) begin
          nonce_d    = sched_if.nonce_base;
          count_d    = sched_if.nonce_count;
          target_d   = sched_if.target_word;
          msg_addr_d = sched_if.message_addr;
          out_addr_d = sched_if.output_addr;
          done_d     = 1'b0;
          found_d    = 1'b0;
          error_d    = 1'b0;
          tried_d    = '0;
          busy_d     = 1'b1;
          state_d    = (sched_if.nonce_count == 32'd0) ? S_FINISH : S_RESET_CORE;
        end
      end
      S_RESET_CORE: state_d = S_START_CORE;
      S_START_CORE: begin
        timer_d = '0;
        state_d = S_WAIT_CORE;
      end
      S_WAIT_CORE: begin
        timer_d = timer_q + 16'd1;
        if (sched_if.core_done) begin
          state_d = S_RD_ADDR;
        end else if (timer_q + 16'd1 == TIMEOUT_CYCLES) begin
          error_d = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = S_CHECK;
      S_CHECK: begin
        tried_d = tried_q + 32'd1;
        nonce_d = nonce_q + 32'd1;
        if (hit && !found_q) begin
          found_d       = 1'b1;
          found_nonce_d = nonce_q;
          found_hash0_d = sched_if.mem_read_data;
        end
        if ((hit && STOP_ON_HIT) || (tried_d == count_q)) state_d = S_FINISH;
        else                                              state_d = S_RESET_CORE;
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort only redirects the sequence; partial results of the job stay intact.
    if (sched_if.abort && state_q != S_IDLE && state_q != S_FINISH) begin
      state_d = S_FINISH;
      error_d = error_q;
    end
  end

  assign core_owns_mem = (state_q == S_START_CORE) || (state_q == S_WAIT_CORE);

  always_comb begin
    sched_if.mem_we         = 1'b0;
    sched_if.mem_addr       = '0;
    sched_if.mem_write_data = '0;
    if (core_owns_mem) begin
      sched_if.mem_we         = sched_if.core_mem_we;
      sched_if.mem_addr       = sched_if.core_mem_addr;
      sched_if.mem_write_data = sched_if.core_mem_write_data;
    end else if (state_q == S_RESET_CORE) begin
      sched_if.mem_we         = 1'b1;
      sched_if.mem_addr       = msg_addr_q + NONCE_OFFSET;
      sched_if.mem_write_data = nonce_q;
    end else if (state_q == S_RD_ADDR || state_q == S_RD_WAIT || state_q == S_CHECK) begin
      sched_if.mem_addr       = out_addr_q;
    end
  end

  // Core is held in reset while the scheduler resets or parks it, and during reset.
  assign sched_if.core_rst_n   = !reset && (state_q != S_RESET_CORE) && (state_q != S_FINISH);
  assign sched_if.core_start   = (state_q == S_START_CORE);
  assign sched_if.busy         = busy_q;
  assign sched_if.done         = done_q;
  assign sched_if.found        = found_q;
  assign sched_if.error        = error_q;
  assign sched_if.found_nonce  = found_nonce_q;
  assign sched_if.found_hash0  = found_hash0_q;
  assign sched_if.nonces_tried = tried_q;
endmodule
`default_nettype wire

// File: tb/tb_sha256_nonce_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_sha256_nonce_scheduler
// Brief   : Directed and random jobs against a nonce-loop reference model
// Revision: 1.0
// ============================================================================
module tb_sha256_nonce_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start_r [2];
  logic        abort_r [2];
  logic [31:0] base_r, count_r, target_r, salt_r, hit_lo_r, hit_n_r;
  logic [15:0] maddr_r, oaddr_r;
  int          lat_r;
  logic        hang_r;

  int nchk  = 0;
  int nfail = 0;

  logic        obs_busy [2], obs_done [2], obs_found [2], obs_error [2];
  logic        obs_crn [2], obs_cstart [2], obs_mwe [2];
  logic [31:0] obs_fn [2], obs_fh [2], obs_tried [2];
  int          obs_starts [2], obs_stray [2];

  logic [31:0] exp_n [$];
  logic        e_found, e_err;
  logic [31:0] e_fn, e_fh, e_tried;

  // Stand-in for H0: a fixed 0x10 inside the hit window, a scrambled word elsewhere.
  function automatic logic [31:0] h0_of(input logic [31:0] n, input logic [31:0] salt,
                                        input logic [31:0] lo, input logic [31:0] hn);
    if (n - lo < hn) return 32'h0000_0010;
    return ((n ^ salt) * 32'h9E37_79B1) | 32'h0100_0000;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sha256_nonce_scheduler_if bus ();
    logic [31:0] mem [256];
    logic [31:0] rd_q = '0;
    logic        running = 1'b0, cdone = 1'b0, cwe = 1'b0;
    logic [15:0] caddr = '0;
    logic [31:0] cdata = '0, hval = '0;
    int          cyc = 0, starts = 0, stray = 0;
    logic [31:0] nlog [$];

    assign bus.start               = start_r[g];
    assign bus.abort               = abort_r[g];
    assign bus.nonce_base          = base_r;
    assign bus.nonce_count         = count_r;
    assign bus.target_word         = target_r;
    assign bus.message_addr        = maddr_r;
    assign bus.output_addr         = oaddr_r;
    assign bus.core_done           = cdone;
    assign bus.core_mem_we         = cwe;
    assign bus.core_mem_addr       = caddr;
    assign bus.core_mem_write_data = cdata;
    assign bus.mem_read_data       = rd_q;

    assign obs_busy[g]   = bus.busy;
    assign obs_done[g]   = bus.done;
    assign obs_found[g]  = bus.found;
    assign obs_error[g]  = bus.error;
    assign obs_crn[g]    = bus.core_rst_n;
    assign obs_cstart[g] = bus.core_start;
    assign obs_mwe[g]    = bus.mem_we;
    assign obs_fn[g]     = bus.found_nonce;
    assign obs_fh[g]     = bus.found_hash0;
    assign obs_tried[g]  = bus.nonces_tried;
    assign obs_starts[g] = starts;
    assign obs_stray[g]  = stray;

    sha256_nonce_scheduler #(
      .NONCE_OFFSET  (16'd19),
      .TIMEOUT_CYCLES(16'd200),
      .STOP_ON_HIT   (g == 0 ? 1'b1 : 1'b0)
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .sched_if(bus)
    );

    // Core model: hashes the nonce it finds in memory, writes H0 back, then raises done.
    always @(posedge clk) begin
      cwe <= 1'b0;
      if (!bus.core_rst_n) begin
        running <= 1'b0;
        cdone   <= 1'b0;
        cyc     <= 0;
      end else if (bus.core_start) begin
        running <= 1'b1;
        cdone   <= 1'b0;
        cyc     <= 0;
        starts  <= starts + 1;
        hval    <= h0_of(mem[8'(maddr_r + 16'd19)], salt_r, hit_lo_r, hit_n_r);
      end else if (running && !hang_r) begin
        cyc <= cyc + 1;
        if (cyc == lat_r - 2) begin
          cwe   <= 1'b1;
          caddr <= oaddr_r;
          cdata <= hval;
        end
        if (cyc == lat_r - 1) begin
          cdone   <= 1'b1;
          running <= 1'b0;
        end
      end
    end

    always @(posedge clk) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr[7:0]] <= bus.mem_write_data;
        if (bus.mem_addr == maddr_r + 16'd19) nlog.push_back(bus.mem_write_data);
        else if (bus.mem_addr != oaddr_r)     stray <= stray + 1;
      end
      rd_q <= mem[bus.mem_addr[7:0]];
    end
  end

  function automatic int nlog_size(input int k);
    return (k == 0) ? g_dut[0].nlog.size() : g_dut[1].nlog.size();
  endfunction

  function automatic logic [31:0] nlog_at(input int k, input int i);
    return (k == 0) ? g_dut[0].nlog[i] : g_dut[1].nlog[i];
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    nchk++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic setup(input logic [31:0] base, input logic [31:0] cnt, input logic [31:0] tgt,
                       input int lat, input logic hang, input logic [31:0] lo, input logic [31:0] hn);
    base_r = base; count_r = cnt; target_r = tgt; lat_r = lat; hang_r = hang;
    hit_lo_r = lo; hit_n_r = hn;
  endtask

  // Reference: try nonces in order, stop on first hit (if enabled) or when the range is used up.
  task automatic run_model(input logic stop);
    logic [31:0] n, h;
    exp_n.delete();
    e_found = 1'b0; e_err = 1'b0; e_fn = '0; e_fh = '0; e_tried = '0;
    for (longint i = 0; i < longint'(count_r); i++) begin
      n = base_r + 32'(i);
      exp_n.push_back(n);
      if (hang_r) begin
        e_err = 1'b1;
        break;
      end
      h = h0_of(n, salt_r, hit_lo_r, hit_n_r);
      e_tried = 32'(i + 1);
      if (h < target_r && !e_found) begin
        e_found = 1'b1; e_fn = n; e_fh = h;
      end
      if (h < target_r && stop) break;
    end
  endtask

  task automatic run_job(input int k, input string tag, input logic poke);
    int s0, n0, st0, t_start, t_err, c_fin;
    logic fin;
    logic [31:0] keep_base;
    run_model(k == 0);
    s0 = obs_starts[k]; n0 = nlog_size(k); st0 = obs_stray[k];
    keep_base = base_r;
    t_start = -1; t_err = -1; c_fin = -1; fin = 1'b0;
    @(negedge clk); start_r[k] = 1'b1;
    @(negedge clk); start_r[k] = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (obs_cstart[k] && t_start < 0) t_start = c;
      if (obs_error[k] && t_err < 0)    t_err = c;
      if (!obs_busy[k] && obs_done[k]) begin
        fin = 1'b1; c_fin = c;
        break;
      end
      if (poke && c == 10) begin start_r[k] = 1'b1; base_r = ~keep_base; end
      if (poke && c == 11) begin start_r[k] = 1'b0; base_r = keep_base; end
      @(negedge clk);
    end
    chk({tag, "/finished"}, 32'(fin), 32'd1);
    chk({tag, "/error"}, 32'(obs_error[k]), 32'(e_err));
    chk({tag, "/found"}, 32'(obs_found[k]), 32'(e_found));
    chk({tag, "/tried"}, obs_tried[k], e_tried);
    if (e_found) begin
      chk({tag, "/found_nonce"}, obs_fn[k], e_fn);
      chk({tag, "/found_hash0"}, obs_fh[k], e_fh);
    end
    chk({tag, "/core_starts"}, 32'(obs_starts[k] - s0), 32'(exp_n.size()));
    chk({tag, "/nonce_writes"}, 32'(nlog_size(k) - n0), 32'(exp_n.size()));
    for (int i = 0; i < exp_n.size() && n0 + i < nlog_size(k); i++)
      chk({tag, "/nonce_value"}, nlog_at(k, n0 + i), exp_n[i]);
    chk({tag, "/stray_writes"}, 32'(obs_stray[k] - st0), 32'd0);
    if (hang_r) chk({tag, "/timeout_cycles"}, 32'(t_err - t_start), 32'd201);
    if (count_r == 32'd0) chk({tag, "/zero_count_latency"}, 32'(c_fin), 32'd1);
  endtask

  initial begin
    int s0;
    logic seen;
    start_r = '{1'b0, 1'b0};
    abort_r = '{1'b0, 1'b0};
    setup(32'd0, 32'd0, 32'd0, 4, 1'b0, 32'd0, 32'd0);
    salt_r  = $urandom;
    maddr_r = {8'($urandom), 8'($urandom_range(0, 100))};
    oaddr_r = {8'($urandom), 8'($urandom_range(160, 250))};
    reset   = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset/busy", 32'(obs_busy[k]), 32'd0);
      chk("reset/done", 32'(obs_done[k]), 32'd0);
      chk("reset/core_rst_n", 32'(obs_crn[k]), 32'd0);
      chk("reset/mem_we", 32'(obs_mwe[k]), 32'd0);
      chk("reset/tried", obs_tried[k], 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("idle/core_rst_n", 32'(obs_crn[0]), 32'd1);

    setup(32'd5, 32'd3, 32'd0, 6, 1'b0, 32'd0, 32'd0);
    run_job(0, "no_hit", 1'b0);
    setup(32'd5, 32'd3, 32'h100, 6, 1'b0, 32'd6, 32'd1);
    run_job(0, "stop_on_hit", 1'b0);
    setup(32'd5, 32'd3, 32'h100, 5, 1'b0, 32'd6, 32'd2);
    run_job(1, "scan_all", 1'b0);
    setup(32'd40, 32'd4, 32'hFFFF_FFFF, 5, 1'b1, 32'd0, 32'd0);
    run_job(0, "timeout", 1'b0);
    setup(32'hFFFF_FFFF, 32'd2, 32'd0, 4, 1'b0, 32'd0, 32'd0);
    run_job(0, "nonce_wrap", 1'b0);
    setup(32'd9, 32'd0, 32'hFFFF_FFFF, 4, 1'b0, 32'd0, 32'd0);
    run_job(0, "zero_count", 1'b0);
    setup(32'd100, 32'd3, 32'd0, 6, 1'b0, 32'd0, 32'd0);
    run_job(1, "start_while_busy", 1'b1);

    s0 = obs_starts[0];
    @(negedge clk); start_r[0] = 1'b1; abort_r[0] = 1'b1;
    @(negedge clk); start_r[0] = 1'b0; abort_r[0] = 1'b0;
    @(negedge clk);
    chk("idle_abort/busy", 32'(obs_busy[0]), 32'd0);
    chk("idle_abort/done", 32'(obs_done[0]), 32'd1);
    chk("idle_abort/starts", 32'(obs_starts[0] - s0), 32'd0);

    for (int j = 0; j < 6; j++) begin
      salt_r = $urandom;
      setup((j % 3 == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom,
            32'($urandom_range(1, 6)), $urandom >> $urandom_range(0, 4),
            $urandom_range(3, 10), 1'b0, 32'd0, 32'd0);
      run_job(j % 2, "random", 1'b0);
    end

    // Abort during the third core run of a full-range job.
    setup($urandom, 32'hFFFF_FFFF, 32'd0, 8, 1'b0, 32'd0, 32'd0);
    s0 = obs_starts[1];
    @(negedge clk); start_r[1] = 1'b1;
    @(negedge clk); start_r[1] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      if (obs_starts[1] - s0 == 3) seen = 1'b1;
      else @(negedge clk);
    end
    chk("abort/reached_third_run", 32'(seen), 32'd1);
    repeat (2) @(negedge clk);
    abort_r[1] = 1'b1;
    @(negedge clk); abort_r[1] = 1'b0;
    chk("abort/core_parked", 32'(obs_crn[1]), 32'd0);
    @(negedge clk);
    chk("abort/done", 32'(obs_done[1]), 32'd1);
    chk("abort/busy", 32'(obs_busy[1]), 32'd0);
    chk("abort/core_rst_n_idle", 32'(obs_crn[1]), 32'd1);
    chk("abort/tried", obs_tried[1], 32'd2);
    chk("abort/error", 32'(obs_error[1]), 32'd0);

    // Asynchronous reset in the middle of a job.
    setup(32'd77, 32'd5, 32'd0, 8, 1'b0, 32'd0, 32'd0);
    s0 = obs_starts[0];
    @(negedge clk); start_r[0] = 1'b1;
    @(negedge clk); start_r[0] = 1'b0;
    for (int c = 0; c < 500 && obs_starts[0] - s0 < 2; c++) @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset/busy", 32'(obs_busy[0]), 32'd0);
    chk("midreset/done", 32'(obs_done[0]), 32'd0);
    chk("midreset/core_rst_n", 32'(obs_crn[0]), 32'd0);
    chk("midreset/core_start", 32'(obs_cstart[0]), 32'd0);
    chk("midreset/mem_we", 32'(obs_mwe[0]), 32'd0);
    chk("midreset/tried", obs_tried[0], 32'd0);
    @(negedge clk); reset = 1'b0;
    salt_r = $urandom;
    setup(32'd300, 32'd4, 32'h4000_0000, 5, 1'b0, 32'd0, 32'd0);
    run_job(0, "after_reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sha256_nonce_scheduler.md
Name: sha256_nonce_scheduler

Overview:
Sequences a single simplified_sha256 core through a range of nonces for the Bitcoin hasher. Per nonce it:
- patches the nonce word into the message buffer;
- resets and starts the core, then waits for the core's done;
- reads hash word H0 from the output buffer and compares it against a target.

It owns the shared message/output memory port and hands the port to the core only while the core runs.

Parameters:
NONCE_OFFSET, 16'd19, word index of nonce within message (message_addr + NONCE_OFFSET)
TIMEOUT_CYCLES, 16'd200, max cycles in WAIT_CORE before error
STOP_ON_HIT, 1'b1, 1 = finish at first hit; 0 = scan whole range, keep first hit

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  job request, sampled in IDLE only
abort  in  1  cancel job, any state
nonce_base  in  32  first nonce
nonce_count  in  32  number of nonces to try
target_word  in  32  hit if H0 < target_word (unsigned)
message_addr  in  16  message base address, passed to core unchanged
output_addr  in  16  hash base address, passed to core unchanged
busy  out  1  high from start accept until FINISH
done  out  1  level, high in FINISH/IDLE after a job, cleared on next start accept
found  out  1  at least one hit in the last job
error  out  1  core timeout in the last job
found_nonce  out  32  nonce of first hit
found_hash0  out  32  H0 of first hit
nonces_tried  out  32  completed nonces in current/last job
core_rst_n  out  1  active-low reset to core
core_start  out  1  one-cycle start pulse to core
core_done  in  1  core done level
core_mem_we  in  1  core memory write enable
core_mem_addr  in  16  core memory address
core_mem_write_data  in  32  core memory write data
mem_we  out  1  memory write enable
mem_addr  out  16  memory address
mem_write_data  out  32  memory write data
mem_read_data  in  32  memory read data, valid one cycle after address presented

Behaviour:
Reset values:
- all outputs 0, except core_rst_n = 0 while reset is high;
- state IDLE; internal nonce/counters 0.

Memory port mux (combinational):
- in START_CORE and WAIT_CORE, mem_* = core_mem_*;
- in all other states, mem_* come from scheduler registers.

States:
- IDLE: core_rst_n = 1, mem_we = 0.
  - start & !abort: latch inputs; nonce = nonce_base; clear done/found/error/nonces_tried; busy = 1.
  - Then go to FINISH if nonce_count == 0, else RESET_CORE.
- RESET_CORE, 1 cycle: core_rst_n = 0; mem_we = 1; mem_addr = message_addr + NONCE_OFFSET; mem_write_data = nonce. Next: START_CORE.
- START_CORE, 1 cycle: core_rst_n = 1; core_start = 1; timeout counter = 0. Next: WAIT_CORE.
- WAIT_CORE: core_start = 0; counter increments.
  - core_done: go to RD_ADDR.
  - Counter == TIMEOUT_CYCLES without done: error = 1, go to FINISH.
  - core_done wins if both occur in the same cycle.
- RD_ADDR: mem_we = 0; mem_addr = output_addr. Next: RD_WAIT.
- RD_WAIT: next: CHECK.
- CHECK: nonces_tried += 1.
  - Hit (mem_read_data < target_word) with found == 0: found = 1; latch found_nonce and found_hash0. Later hits never overwrite.
  - Nonce increments modulo 2^32 (0xFFFFFFFF wraps to 0).
  - Go to FINISH if (hit & STOP_ON_HIT) or nonces_tried + 1 == nonce_count; else RESET_CORE.
- FINISH, 1 cycle: busy = 0; done = 1; core_rst_n = 0 (parks core). Next: IDLE.

Timing: per-nonce latency = 5 + core latency cycles (RESET_CORE, START_CORE, RD_ADDR, RD_WAIT, CHECK).

Boundary conditions:
- start while busy: ignored.
- abort outside IDLE: next state FINISH, error unchanged, results so far kept. abort in IDLE: no effect; it blocks start that cycle.
- reset mid-job: immediate return to reset values; core held in reset.
- nonce_count = 0xFFFFFFFF: counted exactly; nonces_tried compared with 32-bit equality.

Test Plan:
1. nonce_base = 5, nonce_count = 3, target_word = 0 (no hit possible): memory sees nonce writes 5, 6, 7 at message_addr+19; three core_start pulses; done = 1, found = 0, nonces_tried = 3.
2. Core model returns H0 = 0x00000010 only for nonce 6; target_word = 0x100, STOP_ON_HIT = 1: found = 1, found_nonce = 6, found_hash0 = 0x10, nonces_tried = 2, only two core_start pulses.
3. Same as 2 with STOP_ON_HIT = 0, hits on nonces 6 and 7: found_nonce = 6 (first kept), nonces_tried = 3.
4. Core model never asserts core_done: after exactly TIMEOUT_CYCLES in WAIT_CORE, error = 1, done = 1, busy = 0.
5. nonce_base = 0xFFFFFFFF, nonce_count = 2: nonce writes 0xFFFFFFFF then 0x00000000. nonce_count = 0: done asserted 2 cycles after start, no memory write.
6. abort asserted mid-WAIT_CORE, and reset asserted mid-job: FINISH then IDLE with core_rst_n pulsed low; reset forces all outputs to 0 within the same cycle and core_rst_n = 0; a later start runs normally.
